// File: rtl/seg_scan_if.sv
// Display-controller bus: load handshake and live controls in, scan drive out.
interface seg_scan_if #(
    parameter int unsigned NDIG = 8
);
    logic                load;
    logic [4*NDIG-1:0]   value;
    logic                load_ack;
    logic [NDIG-1:0]     blank_mask;
    logic                lz_en;
    logic [3:0]          bright;
    logic [2:0]          digit_sel;
    logic                digit_en;
    logic [3:0]          code;
    logic                bi_l;
    logic                frame_tick;

    modport master (
        output load, value, blank_mask, lz_en, bright,
        input  load_ack, digit_sel, digit_en, code, bi_l, frame_tick
    );

    modport slave (
        input  load, value, blank_mask, lz_en, bright,
        output load_ack, digit_sel, digit_en, code, bi_l, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous loading,
// per-digit blanking, leading-zero suppression and PWM brightness.
module seg_scan_ctrl #(
    parameter int unsigned NDIG     = 8,
    parameter int unsigned PRESCALE = 1024
) (
    input  logic     clk,
    input  logic     reset,
    seg_scan_if.slave bus
);
    localparam int unsigned PW   = $clog2(PRESCALE);
    localparam int unsigned STEP = PRESCALE / 16;

    logic [PW-1:0]      p_q, p_d;
    logic [2:0]         idx_q, idx_d;
    logic [4*NDIG-1:0]  shadow_q, shadow_d;
    logic [4*NDIG-1:0]  pend_q, pend_d;
    logic               pend_flag_q, pend_flag_d;
    logic [2:0]         sel_q, sel_d;
    logic               en_q, en_d;
    logic [3:0]         code_q, code_d;
    logic               bi_l_q, bi_l_d;
    logic               ack_q, ack_d;
    logic               tick_q, tick_d;
    logic               slot_end;
    logic               boundary;

    assign slot_end = (p_q == PW'(PRESCALE - 1));
    assign boundary = slot_end && (idx_q == 3'(NDIG - 1));

    always_comb begin
        p_d         = slot_end ? '0 : p_q + 1'b1;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        sel_d       = sel_q;
        code_d      = code_q;
        bi_l_d      = bi_l_q;
        ack_d       = 1'b0;
        tick_d      = boundary;

        if (slot_end) begin
            idx_d = (idx_q == 3'(NDIG - 1)) ? '0 : idx_q + 3'd1;
        end

        // A load on the boundary edge goes straight to shadow and supersedes pending.
        if (boundary) begin
            pend_flag_d = 1'b0;
            if (bus.load) begin
                shadow_d = bus.value;
                ack_d    = 1'b1;
            end else if (pend_flag_q) begin
                shadow_d = pend_q;
                ack_d    = 1'b1;
            end
        end else if (bus.load) begin
            pend_d      = bus.value;
            pend_flag_d = 1'b1;
        end

        en_d = (p_d != '0) && (32'(p_d) <= 32'(bus.bright) * STEP);

        if (p_d == '0) begin
            sel_d = idx_d;
            for (int unsigned j = 0; j < NDIG; j++) begin
                if (idx_d == 3'(j)) begin
                    code_d = shadow_d[4*j +: 4];
                    bi_l_d = !(bus.blank_mask[j] ||
                               (bus.lz_en && (j != 0) && ((shadow_d >> (4*j)) == '0)));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q         <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            sel_q       <= '0;
            en_q        <= 1'b0;
            code_q      <= '0;
            bi_l_q      <= 1'b0;
            ack_q       <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            p_q         <= p_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            code_q      <= code_d;
            bi_l_q      <= bi_l_d;
            ack_q       <= ack_d;
            tick_q      <= tick_d;
        end
    end

    assign bus.digit_sel  = sel_q;
    assign bus.digit_en   = en_q;
    assign bus.code       = code_q;
    assign bus.bi_l       = bi_l_q;
    assign bus.load_ack   = ack_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random stimulus
// against a cycle-indexed reference model.
module tb_seg_scan_ctrl;
    localparam int unsigned NDIG  = 4;
    localparam int unsigned P     = 16;
    localparam int unsigned FRAME = NDIG * P;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg_scan_if #(.NDIG(NDIG)) bus ();

    seg_scan_ctrl #(.NDIG(NDIG), .PRESCALE(P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state: t counts cycles since reset release.
    int unsigned t     = 0;
    bit          valid = 1'b0;
    logic [15:0] sh_cur;
    bit          win_has;
    logic [15:0] win_val;
    logic [3:0]  prev_bm, slot_bm, cur_bm;
    logic        prev_lz, slot_lz, cur_lz;
    logic [3:0]  prev_br, cur_br;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    endtask

    task automatic step(input logic rst, input logic ld, input logic [15:0] val);
        int unsigned p, s;
        logic        e_ack, e_tick, e_en, e_bi;
        logic [2:0]  e_sel;
        logic [3:0]  e_code;
        @(posedge clk);
        #1;
        reset          = rst;
        bus.load       = ld;
        bus.value      = val;
        bus.blank_mask = cur_bm;
        bus.lz_en      = cur_lz;
        bus.bright     = cur_br;
        @(negedge clk);
        if (valid) begin
            p = t % P;
            s = (t / P) % NDIG;
            e_ack  = 1'b0;
            e_tick = 1'b0;
            if (t > 0 && t % FRAME == 0) begin
                e_tick = 1'b1;
                if (win_has) begin
                    sh_cur = win_val;
                    e_ack  = 1'b1;
                end
                win_has = 1'b0;
            end
            if (p == 0) begin
                slot_bm = prev_bm;
                slot_lz = prev_lz;
            end
            e_en = (p >= 1) && (p <= int'(prev_br) * P / 16);
            if (t < P) begin
                e_sel  = '0;
                e_code = '0;
                e_bi   = 1'b0;
            end else begin
                e_sel  = 3'(s);
                e_code = 4'((sh_cur >> (4*s)) & 16'hF);
                e_bi   = !(slot_bm[s] || (slot_lz && s != 0 && (sh_cur >> (4*s)) == 0));
            end
            check("digit_sel",  32'(bus.digit_sel),  32'(e_sel));
            check("digit_en",   32'(bus.digit_en),   32'(e_en));
            check("code",       32'(bus.code),       32'(e_code));
            check("bi_l",       32'(bus.bi_l),       32'(e_bi));
            check("load_ack",   32'(bus.load_ack),   32'(e_ack));
            check("frame_tick", 32'(bus.frame_tick), 32'(e_tick));
        end
        if (rst) begin
            t       = 0;
            valid   = 1'b1;
            sh_cur  = '0;
            win_has = 1'b0;
            win_val = '0;
            slot_bm = '0;
            slot_lz = 1'b0;
        end else if (valid) begin
            if (ld) begin
                win_has = 1'b1;
                win_val = val;
            end
            t++;
        end
        prev_bm = cur_bm;
        prev_lz = cur_lz;
        prev_br = cur_br;
    endtask

    task automatic run_to(input int unsigned tend);
        while (t < tend) step(1'b0, 1'b0, 16'h0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
    endtask

    initial begin
        reset = 1'b1;
        bus.load = 1'b0;
        bus.value = '0;
        cur_bm = '0;
        cur_lz = 1'b0;
        cur_br = 4'd15;
        prev_bm = '0;
        prev_lz = 1'b0;
        prev_br = 4'd15;

        // Idle scan, then a single load mid-frame
        do_reset();
        run_to(10);
        step(1'b0, 1'b1, 16'h1234);
        run_to(200);

        // Last writer wins; boundary-edge load bypasses pending
        do_reset();
        run_to(5);
        step(1'b0, 1'b1, 16'h1111);
        run_to(20);
        step(1'b0, 1'b1, 16'h2222);
        run_to(100);
        step(1'b0, 1'b1, 16'h9999);
        run_to(127);
        step(1'b0, 1'b1, 16'h3333);
        run_to(260);

        // Leading-zero suppression and blank mask
        do_reset();
        cur_lz = 1'b1;
        step(1'b0, 1'b1, 16'h0070);
        run_to(140);
        step(1'b0, 1'b1, 16'h0000);
        run_to(200);
        cur_bm = 4'b0001;
        run_to(280);
        cur_bm = '0;
        cur_lz = 1'b0;

        // Brightness sweep
        foreach (cur_br[i]) begin end
        cur_br = 4'd0;  run_to(350);
        cur_br = 4'd1;  run_to(420);
        cur_br = 4'd8;  run_to(490);
        cur_br = 4'd15;

        // Reset at slot 2, p=7 with a load pending
        do_reset();
        run_to(20);
        step(1'b0, 1'b1, 16'h5678);
        run_to(39);
        step(1'b1, 1'b0, 16'h0);
        run_to(150);

        // Random stimulus
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 40) == 0) cur_br = 4'($urandom);
            if ($urandom_range(0, 60) == 0) cur_lz = 1'($urandom);
            if ($urandom_range(0, 50) == 0) cur_bm = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 400) == 0) step(1'b1, 1'b0, 16'h0);
            else if ($urandom_range(0, 25) == 0) step(1'b0, 1'b1, 16'($urandom));
            else step(1'b0, 1'b0, 16'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
